alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
Sequencing stage between the UART receiver/ASCII-to-opcode converter and the UART transmitter in the serial ALU calculator.
- Collects three received bytes: operand A, operand B, then the operator character.
- Latches the operator's opcode from the converter, presents A/B/opcode to the combinational ALU, captures the result and hands it to the transmitter with a one-cycle start pulse.
- Abandons a partially received command after a configurable idle timeout.

Parameters:
DBIT, 8, width of data bytes, operands, opcode and ALU result
TIMEOUT_CYC, 50000000, clk cycles of RX inactivity after which a partial command is discarded (0 disables timeout)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
rx_done_tick  in  1  one-cycle pulse: rx_data holds a new received byte
rx_data  in  DBIT  received byte; also drives ASCII input of the external ASCII-to-opcode converter
opcode_in  in  DBIT  converter output for rx_data; 0 means unrecognised character
alu_result  in  DBIT  combinational ALU result for current alu_a/alu_b/alu_op
tx_done_tick  in  1  one-cycle pulse: transmitter finished the byte
alu_a  out  DBIT  registered operand A
alu_b  out  DBIT  registered operand B
alu_op  out  DBIT  registered opcode
tx_data  out  DBIT  registered byte to transmit
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
busy  out  1  high from operator accepted until tx_done_tick
err  out  1  one-cycle pulse on invalid operator or timeout

Behaviour:
- Reset (any time, including mid-command or mid-transmit): state=WAIT_A, alu_a=alu_b=alu_op=tx_data=0, tx_start=0, busy=0, err=0, timeout counter=0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on rx_done_tick, alu_a<=rx_data -> WAIT_B.
- WAIT_B: on rx_done_tick, alu_b<=rx_data -> WAIT_OP.
- WAIT_OP: on rx_done_tick:
  - opcode_in!=0: alu_op<=opcode_in, busy<=1 -> EXEC.
  - opcode_in==0: err pulses next cycle, alu_a/alu_b retain values -> WAIT_A.
- EXEC: one cycle for the ALU to settle on registered inputs; unconditional -> SEND.
- SEND: tx_data<=alu_result, tx_start=1 for exactly this one cycle -> WAIT_TX.
- WAIT_TX: on tx_done_tick, busy<=0 -> WAIT_A.
- Latency: operator rx_done_tick at edge N -> alu_op valid after N, tx_start high during cycle N+2, tx_data valid from N+2 and held until the next SEND.
- rx_done_tick in EXEC/SEND/WAIT_TX is ignored; the byte is dropped and no state changes.
- tx_done_tick outside WAIT_TX is ignored.
- Timeout (TIMEOUT_CYC>0):
  - Counter runs only in WAIT_B and WAIT_OP; cleared on every rx_done_tick and on entry to WAIT_A.
  - When the counter reaches TIMEOUT_CYC-1 without rx_done_tick: err pulse, -> WAIT_A.
  - rx_done_tick in the same cycle as expiry wins: the byte is accepted and there is no error.
- err is registered, high exactly one cycle per event, never asserted in EXEC/SEND/WAIT_TX.
- Counter width is ceil(log2(TIMEOUT_CYC+1)); it must not wrap.

Test Plan:
1. Normal ADD: bytes 8'h05, 8'h03, '+' (opcode_in=8'h20), alu_result model=A+B -> alu_a=5, alu_b=3, alu_op=8'h20; tx_start single pulse 2 cycles after third tick with tx_data=8'h08; busy=1 until tx_done_tick, then 0.
2. Invalid operator: bytes 8'h0A, 8'h02, 'Z' (opcode_in=0) -> one-cycle err, no tx_start, state returns to WAIT_A; next valid triple 8'h07, 8'h01, '-' (8'h22) -> tx_data=8'h06.
3. Timeout with TIMEOUT_CYC=20: send 8'h11 only, idle 20 cycles -> err pulse at cycle 20, state WAIT_A; next byte 8'h44 is latched as alu_a.
4. Bytes during busy: after valid operator, inject rx_done_tick with 8'hFF in WAIT_TX -> alu_a/alu_b/alu_op unchanged, after tx_done_tick next command still starts at WAIT_A.
5. Reset mid-transmit: assert reset in WAIT_TX -> all outputs 0 immediately (async), busy=0; after release a full command (8'h0F, 8'hF0, 'O'=8'h25) produces tx_data=8'hFF.
6. Tick on expiry edge: TIMEOUT_CYC=20, rx_done_tick exactly on cycle 20 -> byte accepted, err stays 0.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Sequencer between UART RX/ASCII converter and UART TX for the serial ALU:
// collects A, B and operator bytes, drives the ALU, forwards the result.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   rx_done_tick, rx_data received-byte strobe and byte
//   opcode_in             converter opcode for rx_data (0 = unrecognised)
//   alu_result            combinational ALU result for alu_a/alu_b/alu_op
//   tx_done_tick          transmitter finished strobe
//   alu_a, alu_b, alu_op  registered ALU inputs
//   tx_data, tx_start     registered result byte and one-cycle start pulse
//   busy, err             command in flight / one-cycle error pulse
module alu_uart_interface #(
   parameter int DBIT        = 8,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [DBIT-1:0] rx_data,
   input  logic [DBIT-1:0] opcode_in,
   input  logic [DBIT-1:0] alu_result,
   input  logic            tx_done_tick,
   output logic [DBIT-1:0] alu_a,
   output logic [DBIT-1:0] alu_b,
   output logic [DBIT-1:0] alu_op,
   output logic [DBIT-1:0] tx_data,
   output logic            tx_start,
   output logic            busy,
   output logic            err
);

   localparam int CW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int TLIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CW-1:0] TLIM_W = CW'(TLIM);
   localparam logic TO_EN = (TIMEOUT_CYC > 0);

   typedef enum logic [2:0] {
      WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            w_collect;
   logic            w_expire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= WAIT_A;
      else       r_state <= w_next;
   end

   // A byte arriving on the expiry cycle takes priority over the timeout.
   always_comb begin
      w_next    = r_state;
      w_collect = (r_state == WAIT_B) || (r_state == WAIT_OP);
      w_expire  = TO_EN && w_collect && !rx_done_tick && (r_cnt == TLIM_W);
      unique case (r_state)
         WAIT_A:  if (rx_done_tick) w_next = WAIT_B;
         WAIT_B: begin
            if (rx_done_tick)  w_next = WAIT_OP;
            else if (w_expire) w_next = WAIT_A;
         end
         WAIT_OP: begin
            if (rx_done_tick)
               w_next = (opcode_in != '0) ? EXEC : WAIT_A;
            else if (w_expire)
               w_next = WAIT_A;
         end
         EXEC:    w_next = SEND;
         SEND:    w_next = WAIT_TX;
         WAIT_TX: if (tx_done_tick) w_next = WAIT_A;
         default: w_next = WAIT_A;
      endcase
   end

   // Idle counter only runs while a command is partially received.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (!TO_EN || !w_collect || rx_done_tick || w_expire)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         err      <= 1'b0;
         unique case (r_state)
            WAIT_A: if (rx_done_tick) alu_a <= rx_data;
            WAIT_B: begin
               if (rx_done_tick)  alu_b <= rx_data;
               else if (w_expire) err   <= 1'b1;
            end
            WAIT_OP: begin
               if (rx_done_tick) begin
                  if (opcode_in != '0) begin
                     alu_op <= opcode_in;
                     busy   <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (w_expire) begin
                  err <= 1'b1;
               end
            end
            // ALU inputs have been stable for a full cycle here.
            SEND: begin
               tx_data  <= alu_result;
               tx_start <= 1'b1;
            end
            WAIT_TX: if (tx_done_tick) busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface with a stub ALU
// and a transaction-level reference model.
module tb_alu_uart_interface;

   localparam int DBIT = 8;
   localparam int TO   = 20;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx_done_tick = 1'b0;
   logic [DBIT-1:0] rx_data = '0;
   logic [DBIT-1:0] opcode_in = '0;
   logic [DBIT-1:0] alu_result;
   logic            tx_done_tick = 1'b0;
   logic [DBIT-1:0] alu_a, alu_b, alu_op, tx_data;
   logic            tx_start, busy, err;

   int n_tests = 0;
   int n_fail  = 0;

   alu_uart_interface #(.DBIT(DBIT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .opcode_in(opcode_in), .alu_result(alu_result),
      .tx_done_tick(tx_done_tick),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .tx_data(tx_data), .tx_start(tx_start),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, b, op);
      case (op)
         8'h20:   return a + b;
         8'h22:   return a - b;
         8'h25:   return a | b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_f(alu_a, alu_b, alu_op);

   // Reference model: byte count, idle time, and a result countdown.
   int         m_n, m_idle, m_cd;
   logic       m_busy, m_txs, m_err;
   logic [7:0] m_a, m_b, m_op, m_txd;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_n = 0; m_idle = 0; m_cd = 0;
         m_busy = 0; m_txs = 0; m_err = 0;
         m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
      end else begin
         m_txs = 0;
         m_err = 0;
         if (!m_busy) begin
            if (rx_done_tick) begin
               m_idle = 0;
               if (m_n == 0) begin
                  m_a = rx_data; m_n = 1;
               end else if (m_n == 1) begin
                  m_b = rx_data; m_n = 2;
               end else begin
                  m_n = 0;
                  if (opcode_in != 0) begin
                     m_op = opcode_in; m_busy = 1; m_cd = 2;
                  end else begin
                     m_err = 1;
                  end
               end
            end else if (m_n > 0) begin
               m_idle = m_idle + 1;
               if (m_idle == TO) begin
                  m_err = 1; m_n = 0; m_idle = 0;
               end
            end
         end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) begin
               m_txs = 1;
               m_txd = alu_f(m_a, m_b, m_op);
            end
         end else if (tx_done_tick) begin
            m_busy = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("m.alu_a", 32'(alu_a), 32'(m_a));
         chk("m.alu_b", 32'(alu_b), 32'(m_b));
         chk("m.alu_op", 32'(alu_op), 32'(m_op));
         chk("m.tx_data", 32'(tx_data), 32'(m_txd));
         chk("m.tx_start", 32'(tx_start), 32'(m_txs));
         chk("m.busy", 32'(busy), 32'(m_busy));
         chk("m.err", 32'(err), 32'(m_err));
      end
   end

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic send(input logic [7:0] d, input logic [7:0] op);
      rx_done_tick = 1'b1;
      rx_data      = d;
      opcode_in    = op;
      @(negedge clk);
      rx_done_tick = 1'b0;
      opcode_in    = '0;
   endtask

   task automatic txdone();
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      idle(3);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.tx_data", 32'(tx_data), 32'd0);
      reset = 1'b0;
      idle(1);

      // 1: normal ADD, tx_start two edges after the operator edge
      send(8'h05, 8'h00);
      send(8'h03, 8'h00);
      send(8'h2B, 8'h20);
      chk("t1.alu_a", 32'(alu_a), 32'h05);
      chk("t1.alu_b", 32'(alu_b), 32'h03);
      chk("t1.alu_op", 32'(alu_op), 32'h20);
      chk("t1.busy", 32'(busy), 32'd1);
      idle(1);
      chk("t1.start_early", 32'(tx_start), 32'd0);
      idle(1);
      chk("t1.tx_start", 32'(tx_start), 32'd1);
      chk("t1.tx_data", 32'(tx_data), 32'h08);
      idle(1);
      chk("t1.start_once", 32'(tx_start), 32'd0);
      idle(3);
      chk("t1.busy_hold", 32'(busy), 32'd1);
      txdone();
      chk("t1.busy_clr", 32'(busy), 32'd0);

      // 2: invalid operator, then a valid SUB
      send(8'h0A, 8'h00);
      send(8'h02, 8'h00);
      send(8'h5A, 8'h00);
      chk("t2.err", 32'(err), 32'd1);
      chk("t2.busy", 32'(busy), 32'd0);
      idle(1);
      chk("t2.err_once", 32'(err), 32'd0);
      send(8'h07, 8'h00);
      send(8'h01, 8'h00);
      send(8'h2D, 8'h22);
      idle(2);
      chk("t2.tx_data", 32'(tx_data), 32'h06);
      txdone();

      // 3: timeout after a lone byte
      send(8'h11, 8'h00);
      idle(TO - 1);
      chk("t3.no_err_yet", 32'(err), 32'd0);
      idle(1);
      chk("t3.err", 32'(err), 32'd1);
      idle(1);
      send(8'h44, 8'h00);
      chk("t3.alu_a", 32'(alu_a), 32'h44);
      idle(TO + 1);

      // 4: bytes while busy are dropped
      send(8'h10, 8'h00);
      send(8'h20, 8'h00);
      send(8'h2B, 8'h20);
      idle(3);
      send(8'hFF, 8'h20);
      chk("t4.alu_a", 32'(alu_a), 32'h10);
      chk("t4.alu_b", 32'(alu_b), 32'h20);
      txdone();
      send(8'h01, 8'h00);
      send(8'h02, 8'h00);
      send(8'h2B, 8'h20);
      idle(2);
      chk("t4.tx_data", 32'(tx_data), 32'h03);

      // 5: async reset while waiting for the transmitter
      idle(2);
      #2 reset = 1'b1;
      #1;
      chk("t5.busy", 32'(busy), 32'd0);
      chk("t5.alu_a", 32'(alu_a), 32'd0);
      chk("t5.tx_data", 32'(tx_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send(8'h0F, 8'h00);
      send(8'hF0, 8'h00);
      send(8'h4F, 8'h25);
      idle(2);
      chk("t5.tx_data", 32'(tx_data), 32'hFF);
      txdone();

      // 6: byte on the expiry edge is accepted
      send(8'h33, 8'h00);
      idle(TO - 1);
      send(8'h34, 8'h00);
      chk("t6.err", 32'(err), 32'd0);
      chk("t6.alu_b", 32'(alu_b), 32'h34);
      send(8'h2B, 8'h20);
      idle(2);
      chk("t6.tx_data", 32'(tx_data), 32'h67);
      txdone();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
